// File: rtl/sd_emmc_dev_cmd.sv
// sd_emmc_dev_cmd: SD/eMMC device-side CMD line receiver and responder.
// Optional receive CRC7 checker enabled by defining SD_EMMC_DEV_CRC_CHK_EN.
module sd_emmc_dev_cmd #(
    parameter int NCR_CYCLES   = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         sd_clk,
    input  logic         rst_n,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_t,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_crc_err,
    input  logic         resp_valid,
    input  logic         resp_none,
    input  logic         resp_long,
    input  logic [5:0]   resp_index,
    input  logic [31:0]  resp_arg,
    input  logic [126:0] resp_payload,
    output logic         resp_ready,
    output logic         resp_timeout,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RESP, TX, TXEND} state_t;
    state_t state, state_nxt;
    logic [46:0]  tok;
    logic [6:0]   crc;
    logic [6:0]   rx_crc;
    logic [7:0]   cnt;
    logic [7:0]   tx_last;
    logic [15:0]  ncr;
    logic [134:0] txs;
    logic         got;
    logic         is_long;
    logic         take;
    logic         go_tx;
    logic         crc_bad;
    logic         tx_bit;

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
    endfunction

`ifdef SD_EMMC_DEV_CRC_CHK_EN
    assign rx_crc  = (cnt >= 8'd8) ? crc_step(crc, cmd_in) : crc;
    assign crc_bad = crc != tok[7:1];
`else
    assign rx_crc  = crc;
    assign crc_bad = 1'b0;
`endif

    assign cmd_index = tok[45:40];
    assign cmd_arg   = tok[39:8];
    assign busy      = state != IDLE;
    assign take      = resp_valid & ~resp_none;
    // Start bit goes out once NCR_CYCLES idle cycles have followed the end bit.
    assign go_tx     = (got | take) & (ncr + 16'd1 >= 16'(NCR_CYCLES));
    assign tx_last   = is_long ? 8'd136 : 8'd48;
    // Short responses carry the running CRC7 in bits 40..46.
    assign tx_bit    = (!is_long && cnt >= 8'd40 && cnt < 8'd47) ? crc[6] : txs[134];

    // State register
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_nxt    = state;
        cmd_valid    = 1'b0;
        cmd_crc_err  = 1'b0;
        resp_ready   = 1'b0;
        resp_timeout = 1'b0;
        case (state)
            IDLE:      state_nxt = cmd_in ? IDLE : RX;
            RX:        state_nxt = (cnt == 8'd0) ? CHECK : RX;
            CHECK: begin
                cmd_valid   = 1'b1;
                cmd_crc_err = ~tok[46] | ~tok[0] | crc_bad;
                state_nxt   = cmd_crc_err ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                resp_ready   = 1'b1;
                resp_timeout = ~resp_none & ~(got | take) & (ncr == 16'(RESP_TIMEOUT));
                state_nxt    = (resp_none | resp_timeout) ? IDLE : go_tx ? TX : WAIT_RESP;
            end
            TX:        state_nxt = (cnt == tx_last) ? TXEND : TX;
            TXEND:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath: token shifter, shared bit counter, CRC7, response shifter, line drivers
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            tok     <= '0;
            crc     <= '0;
            cnt     <= '0;
            ncr     <= '0;
            txs     <= '0;
            got     <= 1'b0;
            is_long <= 1'b0;
            cmd_out <= 1'b1;
            cmd_t   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd46;
                    ncr <= '0;
                    crc <= '0;
                    got <= 1'b0;
                end
                RX: begin
                    tok <= {tok[45:0], cmd_in};
                    cnt <= cnt - 8'd1;
                    crc <= rx_crc;
                end
                CHECK: ncr <= ncr + 16'd1;
                WAIT_RESP: begin
                    ncr <= ncr + 16'd1;
                    if (take && !got) begin
                        got     <= 1'b1;
                        is_long <= resp_long;
                        txs     <= resp_long ? {1'b0, 6'h3f, resp_payload, 1'b1}
                                             : {1'b0, resp_index, resp_arg, 7'd0, 1'b1, 88'd0};
                    end
                    if (state_nxt == TX) begin
                        cmd_out <= 1'b0;
                        cmd_t   <= 1'b0;
                        cnt     <= 8'd1;
                        crc     <= '0;
                    end
                end
                TX: begin
                    cmd_out <= (cnt == tx_last) ? 1'b1 : tx_bit;
                    txs     <= {txs[133:0], 1'b0};
                    crc     <= (cnt < 8'd40) ? crc_step(crc, txs[134]) : {crc[5:0], 1'b0};
                    cnt     <= cnt + 8'd1;
                end
                TXEND: begin
                    cmd_out <= 1'b1;
                    cmd_t   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
